sr_chain_ctrl: RTL and testbench
================================

SR_CHAIN_CTRL -- requirements
Module: sr_chain_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 24: shift-chain length in bits, range 1..64.
REQ-002 SHALL have parameter CLK_DIV, default 4: CLK_SR half-period in CLK_IN cycles, range 1..255.
REQ-003 SHALL have parameter INIT_CYCLES, default 63: post-reset quiet period in CLK_IN cycles, range 0..255.
REQ-004 SHALL have ports: CLK_IN  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have ports: RST  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: START  in  1  frame request, sampled only in IDLE.
REQ-007 SHALL have ports: AUTO  in  1  continuous-refresh mode.
REQ-008 SHALL have ports: TX_DATA  in  NBITS  parallel word to shift out, MSB first.
REQ-009 SHALL have ports: RX_DATA  out  NBITS  last captured serial-input word.
REQ-010 SHALL have ports: BUSY  out  1  high outside IDLE.
REQ-011 SHALL have ports: DONE  out  1  one-cycle frame-complete pulse.
REQ-012 SHALL have ports: ERR  out  1  echo-check mismatch flag (REQ-031).
REQ-013 SHALL have ports: CLK_SR  out  1  shift clock; SR_OUT  out  1  serial data; STROBE_OUT  out  1  latch strobe; SR_IN  in  1  serial data from chain.

Function
REQ-014 SHALL implement states INIT, IDLE, SHIFT, STROBE, DONE.
REQ-015 INIT SHALL last INIT_CYCLES cycles with BUSY=1 and CLK_SR=SR_OUT=STROBE_OUT=0, then go to IDLE; START is ignored in INIT.
REQ-016 In IDLE, START=1 at cycle t SHALL latch TX_DATA, enter SHIFT at t+1 and drive SR_OUT=TX_DATA[NBITS-1] from t+1.
REQ-017 Each bit SHALL take 2*CLK_DIV cycles: CLK_SR low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-018 SR_OUT SHALL change only in the cycle CLK_SR goes 1->0 and is stable while CLK_SR is high.
REQ-019 SR_IN SHALL be sampled in the cycle CLK_SR goes 0->1 and shifted into the receive register LSB; first sampled bit ends at RX_DATA[NBITS-1].
REQ-020 After NBITS bits, CLK_SR SHALL return low and STROBE SHALL hold STROBE_OUT=1 for CLK_DIV cycles.
REQ-021 DONE SHALL pulse for exactly one cycle at t+1+2*CLK_DIV*NBITS+CLK_DIV; RX_DATA SHALL update in the same cycle and hold until the next DONE.
REQ-022 From DONE the block SHALL go to IDLE, or to SHIFT with a fresh TX_DATA latch when AUTO=1 (no IDLE cycle; BUSY stays 1).
REQ-023 START while BUSY=1 SHALL be ignored (not queued).
REQ-024 AUTO deasserted mid-frame SHALL let the current frame complete, then go to IDLE.
REQ-025 TX_DATA changes mid-frame SHALL NOT affect the frame in progress.
REQ-026 Bit counter SHALL be $clog2(NBITS+1) bits and the divider counter $clog2(CLK_DIV+1) bits, with no wrap beyond terminal values.

Reset
REQ-027 RST=0 SHALL asynchronously force state INIT, all counters 0, CLK_SR=SR_OUT=STROBE_OUT=DONE=ERR=0, RX_DATA=0, BUSY=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no DONE and no RX_DATA update; INIT restarts on release.
REQ-029 With INIT_CYCLES=0 the block SHALL enter IDLE on the first clock after reset release.

Configuration
REQ-030 Macro SR_ECHO_CHECK_EN SHALL select the echo check.
REQ-031 With SR_ECHO_CHECK_EN defined, at each DONE ERR SHALL be set to (RX_DATA_new != TX word of the previous frame) and held until the next DONE; the first frame after reset SHALL leave ERR=0.
REQ-032 Without SR_ECHO_CHECK_EN, ERR SHALL be tied 0 and the comparison registers SHALL not exist.

Structure
REQ-033 Package sr_chain_pkg SHALL hold the state enum typedef and the parameter defaults (24, 4, 63).
REQ-034 Sub-module sr_clk_div SHALL generate the CLK_DIV phase tick and CLK_SR edge strobes; the FSM and shift registers remain in sr_chain_ctrl.

Verification (NBITS=24, CLK_DIV=2, INIT_CYCLES=63)
REQ-035 Release reset, START held 1 -> BUSY=1 and CLK_SR=0 for 63 cycles; first frame begins at cycle 64.
REQ-036 START with TX_DATA=24'hA5C3F0 and SR_IN looped to SR_OUT -> 24 CLK_SR pulses of 4-cycle period, STROBE_OUT high 2 cycles, DONE at t+99, RX_DATA=24'hA5C3F0.
REQ-037 AUTO=1 with TX_DATA changed 24'h000001 -> 24'h800000 mid-frame -> first frame shifts 24'h000001, back-to-back second frame shifts 24'h800000, DONE spacing 98 cycles.
REQ-038 START pulsed at cycle 40 of a frame -> ignored; exactly one DONE; IDLE follows.
REQ-039 RST=0 at cycle 50 of a frame -> CLK_SR/SR_OUT/STROBE_OUT=0 immediately, no DONE, RX_DATA=0.
REQ-040 SR_ECHO_CHECK_EN, loopback with SR_IN bit 5 forced 1, TX_DATA=0 twice -> ERR=0 after frame 1, ERR=1 after frame 2.

Source files
------------

// File: rtl/sr_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sr_chain_pkg
//  Purpose  : Shared types and parameter defaults for the serial shift-chain
//             controller (sr_chain_ctrl) and its clock divider (sr_clk_div).
//  Contents : sr_state_t  - controller state encoding
//             c_*_default - default values for NBITS, CLK_DIV, INIT_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
package sr_chain_pkg;

    localparam int c_nbits_default       = 24;
    localparam int c_clk_div_default     = 4;
    localparam int c_init_cycles_default = 63;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4
    } sr_state_t;

endpackage
`default_nettype wire

// File: rtl/sr_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : sr_clk_div
//  Purpose  : Phase divider for the shift clock. Counts CLK_DIV cycles per
//             half-period and flags the cycle on which CLK_SR is about to
//             rise or fall.
//  Ports    : clk        - system clock
//             rst_n      - asynchronous active-low reset
//             i_restart  - synchronous clear back to phase 0 (CLK_SR low)
//             o_clk_sr   - shift clock level
//             o_tick     - last cycle of the current half-period
//             o_rise_stb - o_tick while CLK_SR low  (CLK_SR goes 0->1 next)
//             o_fall_stb - o_tick while CLK_SR high (CLK_SR goes 1->0 next)
//  Revision : 1.0 - initial release
// ============================================================================
module sr_clk_div
    import sr_chain_pkg::*;
#(
    parameter int CLK_DIV = c_clk_div_default
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_clk_sr,
    output logic o_tick,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int              c_cw   = $clog2(CLK_DIV + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

    logic [c_cw-1:0] r_cnt;
    logic            r_phase;
    logic            w_tick;

    assign w_tick = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + c_cw'(1);
        end
    end

    assign o_clk_sr   = r_phase;
    assign o_tick     = w_tick;
    assign o_rise_stb = w_tick & ~r_phase;
    assign o_fall_stb = w_tick &  r_phase;

endmodule
`default_nettype wire

// File: rtl/sr_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr_chain_ctrl
//  Purpose  : Drives an external shift-register chain: shifts TX_DATA out MSB
//             first on SR_OUT/CLK_SR, captures SR_IN into RX_DATA, then pulses
//             STROBE_OUT to latch the chain. Optional continuous refresh (AUTO).
//  Ports    : CLK_IN  - clock            RST        - async active-low reset
//             START   - frame request    AUTO       - back-to-back frames
//             TX_DATA - word to send     RX_DATA    - last captured word
//             BUSY    - not idle         DONE       - frame-complete pulse
//             ERR     - echo mismatch    CLK_SR     - shift clock
//             SR_OUT  - serial out       STROBE_OUT - latch strobe
//             SR_IN   - serial in from the chain
//  Options  : SR_ECHO_CHECK_EN - when defined, each DONE compares the captured
//             word against the word sent in the previous frame (ERR).
//  Revision : 1.0 - initial release
// ============================================================================
module sr_chain_ctrl
    import sr_chain_pkg::*;
#(
    parameter int NBITS       = c_nbits_default,
    parameter int CLK_DIV     = c_clk_div_default,
    parameter int INIT_CYCLES = c_init_cycles_default
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             START,
    input  logic             AUTO,
    input  logic [NBITS-1:0] TX_DATA,
    output logic [NBITS-1:0] RX_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             CLK_SR,
    output logic             SR_OUT,
    output logic             STROBE_OUT,
    input  logic             SR_IN
);

    localparam int             c_bw          = $clog2(NBITS + 1);
    localparam logic [c_bw-1:0] c_last_bit   = c_bw'(NBITS - 1);
    localparam logic [c_bw-1:0] c_bit_max    = c_bw'(NBITS);
    localparam logic [8:0]     c_init_cycles = 9'(INIT_CYCLES);

    sr_state_t         r_state;
    sr_state_t         w_state_next;
    logic [7:0]        r_init_cnt;
    logic [c_bw-1:0]   r_bit_cnt;
    logic [NBITS-1:0]  r_tx_shift;
    logic [NBITS-1:0]  r_rx_shift;
    logic [NBITS-1:0]  r_rx_data;

    logic w_init_done;
    logic w_load;
    logic w_capture;
    logic w_restart;
    logic w_clk_sr;
    logic w_tick;
    logic w_rise_stb;
    logic w_fall_stb;

    // +1 so that INIT_CYCLES=0 still leaves INIT on the first clock.
    assign w_init_done = ({1'b0, r_init_cnt} + 9'd1) >= c_init_cycles;

    // A frame starts either from IDLE on START or straight out of DONE in AUTO.
    assign w_load    = ((r_state == ST_IDLE) && START) || ((r_state == ST_DONE) && AUTO);
    assign w_capture = (r_state == ST_STROBE) && w_tick;

    // Divider runs freely only while shifting or strobing; every state change
    // re-aligns it so each phase starts with a full CLK_DIV count and CLK_SR low.
    assign w_restart = (w_state_next != r_state) ||
                       ((r_state != ST_SHIFT) && (r_state != ST_STROBE));

    sr_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk        (CLK_IN),
        .rst_n      (RST),
        .i_restart  (w_restart),
        .o_clk_sr   (w_clk_sr),
        .o_tick     (w_tick),
        .o_rise_stb (w_rise_stb),
        .o_fall_stb (w_fall_stb)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:   if (w_init_done) w_state_next = ST_IDLE;
            ST_IDLE:   if (START) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (w_fall_stb && (r_bit_cnt == c_last_bit)) w_state_next = ST_STROBE;
            ST_STROBE: if (w_tick) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = AUTO ? ST_SHIFT : ST_IDLE;
            default:   w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_INIT) && !w_init_done) begin
                r_init_cnt <= r_init_cnt + 8'd1;
            end
            if (w_load) begin
                r_tx_shift <= TX_DATA;
                r_bit_cnt  <= '0;
            end
            if (r_state == ST_SHIFT) begin
                // Sample on the cycle CLK_SR rises; first bit migrates to the MSB.
                if (w_rise_stb) begin
                    r_rx_shift <= (r_rx_shift << 1) | NBITS'(SR_IN);
                end
                // Advance data on the falling edge so SR_OUT is stable while high.
                if (w_fall_stb) begin
                    r_tx_shift <= r_tx_shift << 1;
                    if (r_bit_cnt != c_bit_max) begin
                        r_bit_cnt <= r_bit_cnt + c_bw'(1);
                    end
                end
            end
            if (w_capture) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

`ifdef SR_ECHO_CHECK_EN
    // A chain of NBITS stages returns the previous frame's word, so the
    // captured word is checked against what was sent one frame earlier.
    logic [NBITS-1:0] r_tx_word;
    logic [NBITS-1:0] r_prev_tx;
    logic             r_have_prev;
    logic             r_err;

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            r_tx_word   <= '0;
            r_prev_tx   <= '0;
            r_have_prev <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_word <= TX_DATA;
            end
            if (w_capture) begin
                r_err       <= r_have_prev && (r_rx_shift != r_prev_tx);
                r_prev_tx   <= r_tx_word;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    assign RX_DATA    = r_rx_data;
    assign BUSY       = (r_state != ST_IDLE);
    assign DONE       = (r_state == ST_DONE);
    assign STROBE_OUT = (r_state == ST_STROBE);
    assign CLK_SR     = w_clk_sr;
    assign SR_OUT     = r_tx_shift[NBITS-1];

endmodule
`default_nettype wire

// File: tb/tb_sr_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_chain_ctrl
//  Purpose  : Self-checking bench for sr_chain_ctrl (NBITS=24, CLK_DIV=2,
//             INIT_CYCLES=63) with SR_IN looped back to SR_OUT. Expected frames
//             are queued when a frame is requested and retired at each DONE.
//  Options  : SR_ECHO_CHECK_EN - enables expected ERR modelling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_chain_ctrl;

    localparam int c_nbits = 24;
    localparam int c_div   = 2;
    localparam int c_init  = 63;
    localparam int c_frame = 1 + 2 * c_div * c_nbits + c_div;  // START cycle to DONE

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               start      = 1'b0;
    logic               auto_mode  = 1'b0;
    logic [c_nbits-1:0] tx_data    = '0;
    logic [c_nbits-1:0] rx_data;
    logic               busy;
    logic               done;
    logic               err;
    logic               clk_sr;
    logic               sr_out;
    logic               strobe_out;
    logic               sr_in;
    logic               force5     = 1'b0;

    int cyc      = 0;
    int n_total  = 0;
    int n_bad    = 0;
    int rise_cnt = 0;

    typedef struct {
        logic [c_nbits-1:0] rx;
        int                 done_cyc;
        logic               err;
    } exp_t;

    exp_t sb[$];

`ifdef SR_ECHO_CHECK_EN
    logic [c_nbits-1:0] m_prev_tx   = '0;
    logic               m_have_prev = 1'b0;
`endif

    // Loopback; optionally force the bit that lands in RX_DATA[5] high.
    assign sr_in = sr_out | (force5 && (rise_cnt == c_nbits - 1 - 5));

    sr_chain_ctrl #(
        .NBITS       (c_nbits),
        .CLK_DIV     (c_div),
        .INIT_CYCLES (c_init)
    ) dut (
        .CLK_IN     (clk),
        .RST        (rst_n),
        .START      (start),
        .AUTO       (auto_mode),
        .TX_DATA    (tx_data),
        .RX_DATA    (rx_data),
        .BUSY       (busy),
        .DONE       (done),
        .ERR        (err),
        .CLK_SR     (clk_sr),
        .SR_OUT     (sr_out),
        .STROBE_OUT (strobe_out),
        .SR_IN      (sr_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push_exp(input logic [c_nbits-1:0] tx, input logic [c_nbits-1:0] rx,
                            input int dc);
        exp_t e2;
        e2.rx       = rx;
        e2.done_cyc = dc;
`ifdef SR_ECHO_CHECK_EN
        e2.err      = m_have_prev && (rx != m_prev_tx);
        m_prev_tx   = tx;
        m_have_prev = 1'b1;
`else
        e2.err      = 1'b0;
        if (tx === 'x) e2.err = 1'b0;
`endif
        sb.push_back(e2);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: shift-clock shape, strobe length and scoreboard retirement.
    // ------------------------------------------------------------------------
    logic               prev_clk_sr = 1'b0;
    logic               prev_sr_out = 1'b0;
    int                 last_rise   = 0;
    int                 strobe_cnt  = 0;
    int                 done_cnt    = 0;
    int                 last_done   = 0;
    int                 prev_done   = 0;
    logic [c_nbits-1:0] held_rx     = '0;
    logic               held_err    = 1'b0;
    exp_t               e;

    always @(negedge clk) begin
        if (!rst_n) begin
            rise_cnt    <= 0;
            strobe_cnt  <= 0;
            held_rx     <= '0;
            held_err    <= 1'b0;
            prev_clk_sr <= 1'b0;
            prev_sr_out <= 1'b0;
        end else begin
            if (clk_sr && !prev_clk_sr) begin
                if (rise_cnt > 0) chk("sr_period", cyc - last_rise, 2 * c_div);
                rise_cnt  <= rise_cnt + 1;
                last_rise <= cyc;
            end
            if (clk_sr && prev_clk_sr) chk("sr_stable", sr_out, prev_sr_out);
            if (strobe_out) chk("strobe_clk_low", clk_sr, 0);
            if (done) begin
                chk("pulses", rise_cnt, c_nbits);
                chk("strobe_len", strobe_cnt, c_div);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cyc", cyc, e.done_cyc);
                    chk("rx_data", rx_data, e.rx);
                    chk("err", err, e.err);
                    held_rx  <= e.rx;
                    held_err <= e.err;
                end
                rise_cnt   <= 0;
                strobe_cnt <= 0;
                done_cnt   <= done_cnt + 1;
                prev_done  <= last_done;
                last_done  <= cyc;
            end else begin
                chk("rx_hold", rx_data, held_rx);
                chk("err_hold", err, held_err);
                if (strobe_out) strobe_cnt <= strobe_cnt + 1;
            end
            prev_clk_sr <= clk_sr;
            prev_sr_out <= sr_out;
        end
    end

    task automatic wait_done(input int target, input int bound);
        int k = 0;
        while ((done_cnt < target) && (k < bound)) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_timeout", (done_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && (k < bound)) begin
            @(negedge clk); #1;
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic step;
        @(negedge clk); #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int t;

        // Reset state, START held high across INIT.
        rst_n   = 1'b0;
        start   = 1'b1;
        tx_data = 24'hA5C3F0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_clk_sr", clk_sr, 0);
        chk("rst_sr_out", sr_out, 0);
        chk("rst_strobe", strobe_out, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rx", rx_data, 0);

        // First frame begins at cycle 64, DONE 99 cycles after the START cycle.
        push_exp(24'hA5C3F0, 24'hA5C3F0, c_init + c_frame);
        rst_n = 1'b1;
        for (int j = 1; j < c_init; j++) begin
            step();
            chk("init_busy", busy, 1);
            chk("init_clk_sr", clk_sr, 0);
        end
        step();
        chk("idle_after_init", busy, 0);
        step();
        chk("shift_busy", busy, 1);
        chk("first_msb", sr_out, 1);
        start = 1'b0;
        wait_done(1, 2 * c_frame);
        step();
        chk("post_a_idle", busy, 0);

        // START during a frame is ignored; TX change mid-frame has no effect.
        tx_data = 24'h3C5A96;
        start   = 1'b1;
        t       = cyc;
        push_exp(24'h3C5A96, 24'h3C5A96, t + c_frame);
        step();
        start = 1'b0;
        while (cyc < t + 40) step();
        start   = 1'b1;
        tx_data = 24'hFFFFFF;
        step();
        start = 1'b0;
        wait_done(2, 2 * c_frame);
        step();
        chk("post_b_idle", busy, 0);
        repeat (10) step();
        chk("b_single_done", done_cnt, 2);

        // AUTO: back-to-back frames, second frame picks up the new TX word.
        tx_data   = 24'h000001;
        start     = 1'b1;
        auto_mode = 1'b1;
        t         = cyc;
        push_exp(24'h000001, 24'h000001, t + c_frame);
        push_exp(24'h800000, 24'h800000, t + 2 * c_frame);
        step();
        start = 1'b0;
        while (cyc < t + 30) step();
        tx_data = 24'h800000;
        wait_done(3, 2 * c_frame);
        chk("auto_busy_in_done", busy, 1);
        step();
        chk("auto_no_idle", busy, 1);
        chk("auto_msb", sr_out, 1);
        while (cyc < t + c_frame + 50) step();
        auto_mode = 1'b0;
        tx_data   = 24'h123456;
        wait_done(4, 2 * c_frame);
        chk("auto_gap", last_done - prev_done - 1, 98);
        step();
        chk("auto_end_idle", busy, 0);

        // Reset in the middle of a frame (CLK_SR high, SR_OUT high).
        tx_data = 24'hFFFFFF;
        start   = 1'b1;
        t       = cyc;
        push_exp(24'hFFFFFF, 24'hFFFFFF, t + c_frame);
        step();
        start = 1'b0;
        while (cyc < t + 51) step();
        chk("pre_rst_clk_sr", clk_sr, 1);
        chk("pre_rst_sr_out", sr_out, 1);
        rst_n = 1'b0;
        sb.delete();
`ifdef SR_ECHO_CHECK_EN
        m_have_prev = 1'b0;
`endif
        #1;
        chk("abort_clk_sr", clk_sr, 0);
        chk("abort_sr_out", sr_out, 0);
        chk("abort_strobe", strobe_out, 0);
        chk("abort_done", done, 0);
        chk("abort_rx", rx_data, 0);
        chk("abort_busy", busy, 1);
        step();
        rst_n = 1'b1;
        wait_idle(3 * c_init);
        chk("abort_no_done", done_cnt, 4);

        // Two frames of zeros with RX bit 5 forced high.
        force5  = 1'b1;
        tx_data = 24'h000000;
        start   = 1'b1;
        t       = cyc;
        push_exp(24'h000000, 24'h000020, t + c_frame);
        step();
        start = 1'b0;
        wait_done(5, 2 * c_frame);
        step();
        start = 1'b1;
        t     = cyc;
        push_exp(24'h000000, 24'h000020, t + c_frame);
        step();
        start = 1'b0;
        wait_done(6, 2 * c_frame);
        step();
        force5 = 1'b0;
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
